// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITER      = 32;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issue logic and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, busA, busB,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, busA, busB,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared datapath.
// Multiply: shift-add on {partial product, remaining multiplier bits}.
// Divide: restoring shift-subtract on {remainder, remaining dividend / quotient bits}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] accOut
);

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH+1:0] diff;
  logic             unusedDiffBit;

  // diff[WIDTH] is always zero when no borrow occurs, so only the borrow bit matters.
  assign unusedDiffBit = diff[WIDTH];

  // Form both candidate results and pick by mode.
  always_comb begin
    mulSum   = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, opnd} : '0);
    remShift = accIn[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, remShift} - {2'b00, opnd};
    accOut   = '0;
    if (isDiv) begin
      if (diff[WIDTH+1]) begin
        accOut = {remShift[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
      end else begin
        accOut = {diff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
      end
    end else begin
      accOut = {mulSum, accIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: IDLE -> CALC (WIDTH iterations) -> FIX.
// Optional signed support via MULDIV_SIGNED_EN; without it op[0] is ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  logic [1:0]         stateReg;
  logic [CNT_W-1:0]   cntReg;
  logic [2*WIDTH-1:0] accReg;
  logic [2*WIDTH-1:0] stepAcc;
  logic [WIDTH-1:0]   opndReg;
  logic               isDivReg;
  logic               divZeroReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;
  logic               div0Reg;

  logic               startDiv;
  logic               bZero;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

`ifdef MULDIV_SIGNED_EN
  logic startSigned;
  logic aNeg;
  logic bNeg;
  logic negResNext;
  logic negRemNext;
  logic negResReg;
  logic negRemReg;
`endif

  // Decode the request and reduce operands to unsigned magnitudes.
  // A zero divisor keeps the raw dividend so the remainder comes out as busA unchanged.
  always_comb begin
    startDiv = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    bZero    = (bus.busB == '0);
    aMag     = bus.busA;
    bMag     = bus.busB;
`ifdef MULDIV_SIGNED_EN
    startSigned = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    aNeg        = startSigned && bus.busA[WIDTH-1] && !(startDiv && bZero);
    bNeg        = startSigned && bus.busB[WIDTH-1];
    if (aNeg) aMag = -bus.busA;
    if (bNeg) bMag = -bus.busB;
    negResNext  = aNeg ^ bNeg;
    negRemNext  = aNeg;
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv  (isDivReg),
    .accIn  (accReg),
    .opnd   (opndReg),
    .accOut (stepAcc)
  );

  // Sign correction of the finished magnitude result.
  always_comb begin
    fixHi = accReg[2*WIDTH-1:WIDTH];
    fixLo = accReg[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (isDivReg) begin
      if (negResReg) fixLo = -accReg[WIDTH-1:0];
      if (negRemReg) fixHi = -accReg[2*WIDTH-1:WIDTH];
    end else if (negResReg) begin
      {fixHi, fixLo} = -accReg;
    end
`endif
  end

  // Control FSM, iteration counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= S_IDLE;
      cntReg     <= '0;
      accReg     <= '0;
      opndReg    <= '0;
      isDivReg   <= 1'b0;
      divZeroReg <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      div0Reg    <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        S_IDLE: begin
          if (bus.start) begin
            isDivReg   <= startDiv;
            divZeroReg <= startDiv && bZero;
            div0Reg    <= 1'b0;
            cntReg     <= '0;
            if (startDiv) begin
              opndReg <= bMag;
              accReg  <= {{WIDTH{1'b0}}, aMag};
            end else begin
              opndReg <= aMag;
              accReg  <= {{WIDTH{1'b0}}, bMag};
            end
            stateReg <= S_CALC;
          end
        end
        S_CALC: begin
          accReg <= stepAcc;
          cntReg <= cntReg + 1'b1;
          if (cntReg == CNT_W'(WIDTH - 1)) stateReg <= S_FIX;
        end
        S_FIX: begin
          hiReg    <= fixHi;
          loReg    <= fixLo;
          div0Reg  <= divZeroReg;
          doneReg  <= 1'b1;
          stateReg <= S_IDLE;
        end
        default: stateReg <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Result signs captured with the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      negResReg <= 1'b0;
      negRemReg <= 1'b0;
    end else if (stateReg == S_IDLE && bus.start) begin
      negResReg <= negResNext;
      negRemReg <= negRemNext;
    end
  end
`endif

  assign bus.busy = (stateReg != S_IDLE);
  assign bus.done = doneReg;
  assign bus.div0 = div0Reg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results come from plain 64-bit
// arithmetic and are checked by an independent monitor on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          acceptCyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: signedness decided by op[0] only when signed support is built in.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    bit     sgn;
    longint sa, sb2, r64;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    e.div0 = 1'b0;
    e.acceptCyc = 0;
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb2 = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[1]) begin
      r64 = sa * sb2;
      p = 64'(r64);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.div0 = 1'b1;
    end else begin
      e.lo = 32'(sa / sb2);
      e.hi = 32'(sa % sb2);
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("result hi=%h lo=%h div0=%b at cycle %0d", bus.hi, bus.lo, bus.div0, cyc);
          chk("hi", {32'b0, bus.hi}, {32'b0, e.hi});
          chk("lo", {32'b0, bus.lo}, {32'b0, e.lo});
          chk("div0", {63'b0, bus.div0}, {63'b0, e.div0});
          chk("latency", 64'(cyc - e.acceptCyc), 64'(ITER + 1));
        end
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit doExp);
    exp_t e;
    waitIdle();
    bus.start = 1'b1;
    bus.op = o;
    bus.busA = a;
    bus.busB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (doExp) begin
      e = model(o, a, b);
      e.acceptCyc = cyc;
      sb.push_back(e);
    end
    $display("issue op=%b a=%h b=%h", o, a, b);
    chk("busy_after_start", {63'b0, bus.busy}, 64'd1);
  endtask

  initial begin
    exp_t e;
    int n;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.busA = '0;
    bus.busB = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_done", {63'b0, bus.done}, 64'd0);
    chk("rst_div0", {63'b0, bus.div0}, 64'd0);
    chk("rst_hi", {32'b0, bus.hi}, 64'd0);
    chk("rst_lo", {32'b0, bus.lo}, 64'd0);

    // Largest unsigned product, with busy-length measurement.
    issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 64'(n), 64'd33);

    // Reset in the middle of an operation discards it.
    issue(OP_MULU, 32'd7, 32'd6, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst_hi", {32'b0, bus.hi}, 64'd0);
    chk("midrst_lo", {32'b0, bus.lo}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIVU, 32'h0000_1234, 32'd0, 1'b1);
    issue(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b1);
    issue(OP_MULU, 32'd2, 32'd3, 1'b1);
    chk("div0_cleared", {63'b0, bus.div0}, 64'd0);

    // Start during busy is ignored and operand changes do not disturb the result.
    issue(OP_DIVU, 32'd1000, 32'd10, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = OP_MULU;
    bus.busA = 32'd5;
    bus.busB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.busA = 32'd1;
    bus.busB = 32'd1;
    chk("busy_ignore", {63'b0, bus.busy}, 64'd1);

    // Back-to-back: start held through the done cycle.
    waitIdle();
    bus.start = 1'b1;
    bus.op = OP_MULU;
    bus.busA = 32'd3;
    bus.busB = 32'd4;
    @(posedge clk); #1;
    e = model(OP_MULU, 32'd3, 32'd4);
    e.acceptCyc = cyc;
    sb.push_back(e);
    $display("issue op=00 a=3 b=4 (start held)");
    bus.op = OP_DIVU;
    bus.busA = 32'd50;
    bus.busB = 32'd7;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.done !== 1'b1) chk("b2b_done_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    e = model(OP_DIVU, 32'd50, 32'd7);
    e.acceptCyc = cyc;
    sb.push_back(e);
    $display("issue op=10 a=50 b=7 (back-to-back)");
    bus.start = 1'b0;
    chk("b2b_busy", {63'b0, bus.busy}, 64'd1);

    // Randomized mix with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
